rf_alu_pipe: RTL and testbench

//  Parametrised register file with a registered LEGv8-style ALU stage; successor to the fixed 32x64 RF+ALU.

---
 rtl/rf_alu_pipe.sv | 191 +++++++++++++++++++
 tb/tb_rf_alu_pipe.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_alu_pipe.sv
// ---------------------------------------------------------------------------
// rf_alu_pipe
//   Parametrised register file feeding a registered LEGv8-style ALU stage.
//   Two combinational read ports (with a same-cycle write-to-read bypass and
//   an optional hardwired zero register), one synchronous write port, and a
//   one-cycle valid-qualified ALU pipeline stage producing a result plus
//   NZCV flags.
//
// Handshake: in_valid qualifies Read1/Read2/ALUOp/Opcode for one cycle; the
//   result appears exactly one rising edge later with out_valid=1. There is no
//   ready/backpressure, so an operation may be accepted every cycle. While
//   out_valid=0 the result and flag outputs hold their last computed values.
//
// Ports
//   clock, reset        rising-edge clock, asynchronous active-high reset
//   in_valid            operation present this cycle
//   Read1, Read2        operand A / operand B register indices
//   WriteReg, WriteData register write index / data
//   RegWrite            write enable, sampled on the rising edge
//   ALUOp, Opcode       ALU control (00 ADD, 01 pass B, 10 decode, 11 zero)
//   out_valid           ALU_Result and flags hold a new result
//   ALU_Result          registered ALU result
//   Zero, Negative      result == 0, result sign bit
//   Carry, Overflow     carry-out / no-borrow, signed overflow (ADD/SUB only)
// ---------------------------------------------------------------------------
module rf_alu_pipe #(
    parameter int DATA_W   = 64,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter int ZERO_REG = 31
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] Read1,
    input  logic [ADDR_W-1:0] Read2,
    input  logic [ADDR_W-1:0] WriteReg,
    input  logic [DATA_W-1:0] WriteData,
    input  logic              RegWrite,
    input  logic [1:0]        ALUOp,
    input  logic [10:0]       Opcode,
    output logic              out_valid,
    output logic [DATA_W-1:0] ALU_Result,
    output logic              Zero,
    output logic              Negative,
    output logic              Carry,
    output logic              Overflow
);

    localparam logic [10:0] OPC_AND  = 11'b10001010000;
    localparam logic [10:0] OPC_ORR  = 11'b10101010000;
    localparam logic [10:0] OPC_ADD  = 11'b10001011000;
    localparam logic [10:0] OPC_SUB  = 11'b11001011000;
    localparam logic [10:0] OPC_PASS = 11'b11111000010;
    localparam logic [10:0] OPC_NOR  = 11'b11101010000;

    typedef enum logic [2:0] {
        K_ADD, K_SUB, K_AND, K_ORR, K_NOR, K_PASSB, K_ZERO
    } alu_kind_e;

    // An index is backed by real storage only if it is in range and is not
    // the zero register. Compared as int so an out-of-range ZERO_REG never
    // aliases onto a real index through truncation.
    function automatic logic is_live(input logic [ADDR_W-1:0] idx);
        return (int'(idx) < NUM_REGS) && (int'(idx) != ZERO_REG);
    endfunction

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              zero_q, zero_d;
    logic              neg_q, neg_d;
    logic              carry_q, carry_d;
    logic              ovf_q, ovf_d;

    logic              wr_live;
    logic [DATA_W-1:0] op_a, op_b;
    alu_kind_e         kind;
    logic [DATA_W-1:0] addend_b;
    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] alu_res;
    logic              alu_c, alu_v;

    assign wr_live = RegWrite && is_live(WriteReg);

    // Operand read: dead index -> 0, pending write to same index -> bypass.
    always_comb begin
        op_a = '0;
        if (is_live(Read1)) begin
            op_a = (wr_live && (WriteReg == Read1)) ? WriteData : regs_q[Read1];
        end
        op_b = '0;
        if (is_live(Read2)) begin
            op_b = (wr_live && (WriteReg == Read2)) ? WriteData : regs_q[Read2];
        end
    end

    always_comb begin
        kind = K_ZERO;
        unique case (ALUOp)
            2'b00: kind = K_ADD;
            2'b01: kind = K_PASSB;
            2'b10: begin
                case (Opcode)
                    OPC_AND:  kind = K_AND;
                    OPC_ORR:  kind = K_ORR;
                    OPC_ADD:  kind = K_ADD;
                    OPC_SUB:  kind = K_SUB;
                    OPC_PASS: kind = K_PASSB;
                    OPC_NOR:  kind = K_NOR;
                    default:  kind = K_ZERO;
                endcase
            end
            default: kind = K_ZERO;
        endcase
    end

    // One shared adder: SUB is A + ~B + 1, so Carry reads as no-borrow.
    always_comb begin
        addend_b = (kind == K_SUB) ? ~op_b : op_b;
        sum      = {1'b0, op_a} + {1'b0, addend_b}
                 + {{DATA_W{1'b0}}, (kind == K_SUB)};
        alu_res  = '0;
        alu_c    = 1'b0;
        alu_v    = 1'b0;
        case (kind)
            K_ADD, K_SUB: begin
                alu_res = sum[DATA_W-1:0];
                alu_c   = sum[DATA_W];
                alu_v   = (op_a[DATA_W-1] == addend_b[DATA_W-1]) &&
                          (sum[DATA_W-1] != op_a[DATA_W-1]);
            end
            K_AND:   alu_res = op_a & op_b;
            K_ORR:   alu_res = op_a | op_b;
            K_NOR:   alu_res = ~(op_a | op_b);
            K_PASSB: alu_res = op_b;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        regs_d = regs_q;
        if (wr_live) begin
            regs_d[WriteReg] = WriteData;
        end
        out_valid_d = in_valid;
        result_d    = result_q;
        zero_d      = zero_q;
        neg_d       = neg_q;
        carry_d     = carry_q;
        ovf_d       = ovf_q;
        if (in_valid) begin
            result_d = alu_res;
            zero_d   = (alu_res == '0);
            neg_d    = alu_res[DATA_W-1];
            carry_d  = alu_c;
            ovf_d    = alu_v;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            neg_q       <= 1'b0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            regs_q      <= regs_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            neg_q       <= neg_d;
            carry_q     <= carry_d;
            ovf_q       <= ovf_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign ALU_Result = result_q;
    assign Zero       = zero_q;
    assign Negative   = neg_q;
    assign Carry      = carry_q;
    assign Overflow   = ovf_q;

endmodule

// File: tb/tb_rf_alu_pipe.sv
// ---------------------------------------------------------------------------
// tb_rf_alu_pipe
//   Self-checking bench for rf_alu_pipe at default parameters (64 x 32,
//   zero register 31). Inputs are driven on the falling edge and outputs are
//   sampled on the following falling edge, half a cycle after the DUT edge.
// ---------------------------------------------------------------------------
module tb_rf_alu_pipe;

    localparam int W = 64;

    localparam logic [10:0] OPC_AND  = 11'b10001010000;
    localparam logic [10:0] OPC_ORR  = 11'b10101010000;
    localparam logic [10:0] OPC_ADD  = 11'b10001011000;
    localparam logic [10:0] OPC_SUB  = 11'b11001011000;
    localparam logic [10:0] OPC_PASS = 11'b11111000010;
    localparam logic [10:0] OPC_NOR  = 11'b11101010000;

    localparam logic signed [65:0] S_MAX = 66'sh0_7FFF_FFFF_FFFF_FFFF;
    localparam logic signed [65:0] S_MIN = 66'sh3_8000_0000_0000_0000;

    // ---------------- clock / reset / DUT ----------------
    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic [4:0]   Read1 = '0, Read2 = '0, WriteReg = '0;
    logic [W-1:0] WriteData = '0;
    logic         RegWrite = 1'b0;
    logic [1:0]   ALUOp = '0;
    logic [10:0]  Opcode = '0;
    logic         out_valid;
    logic [W-1:0] ALU_Result;
    logic         Zero, Negative, Carry, Overflow;

    always #5 clock = ~clock;

    rf_alu_pipe dut (
        .clock(clock), .reset(reset), .in_valid(in_valid),
        .Read1(Read1), .Read2(Read2), .WriteReg(WriteReg),
        .WriteData(WriteData), .RegWrite(RegWrite),
        .ALUOp(ALUOp), .Opcode(Opcode),
        .out_valid(out_valid), .ALU_Result(ALU_Result),
        .Zero(Zero), .Negative(Negative), .Carry(Carry), .Overflow(Overflow)
    );

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] model_regs [32];
    // Packed expectation: {valid, result, Z, N, C, V}
    logic [W+4:0] exp_q [$];

    task automatic chk(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [W+4:0] e);
        chk({tag, " out_valid"}, W'(out_valid), W'(e[W+4]));
        chk({tag, " result"},    ALU_Result,    e[W+3:4]);
        chk({tag, " Z"},         W'(Zero),      W'(e[3]));
        chk({tag, " N"},         W'(Negative),  W'(e[2]));
        chk({tag, " C"},         W'(Carry),     W'(e[1]));
        chk({tag, " V"},         W'(Overflow),  W'(e[0]));
    endtask

    // ---------------- reference model ----------------
    // Returns {result, Z, N, C, V} from the architectural operation rules.
    function automatic logic [W+3:0] alu_model(input logic [1:0] op,
            input logic [10:0] opc, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] r;
        logic c, v;
        logic signed [65:0] sa, sb, sr;
        int kind; // 0 add, 1 sub, 2 logical/other
        r = '0; c = 1'b0; v = 1'b0; kind = 2;
        sa = $signed({{2{a[W-1]}}, a});
        sb = $signed({{2{b[W-1]}}, b});
        case (op)
            2'b00: kind = 0;
            2'b01: r = b;
            2'b10: begin
                if (opc == OPC_AND)       r = a & b;
                else if (opc == OPC_ORR)  r = a | b;
                else if (opc == OPC_ADD)  kind = 0;
                else if (opc == OPC_SUB)  kind = 1;
                else if (opc == OPC_PASS) r = b;
                else if (opc == OPC_NOR)  r = ~(a | b);
                else                      r = '0;
            end
            default: r = '0;
        endcase
        if (kind == 0) begin
            r  = a + b;
            c  = (r < a);                 // unsigned wrap-around
            sr = sa + sb;
            v  = (sr > S_MAX) || (sr < S_MIN);
        end else if (kind == 1) begin
            r  = a - b;
            c  = (a >= b);                // no borrow
            sr = sa - sb;
            v  = (sr > S_MAX) || (sr < S_MIN);
        end
        return {r, (r == '0), r[W-1], c, v};
    endfunction

    function automatic logic [W-1:0] model_read(input logic [4:0] idx,
            input logic we, input logic [4:0] wr, input logic [W-1:0] wd);
        if (idx == 5'd31) return '0;
        if (we && wr == idx) return wd;
        return model_regs[idx];
    endfunction

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        in_valid = 1'b0; RegWrite = 1'b0;
        Read1 = '0; Read2 = '0; WriteReg = '0; WriteData = '0;
        ALUOp = '0; Opcode = '0;
    endtask

    task automatic reset_dut();
        @(negedge clock);
        idle_inputs();
        reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 32; i++) model_regs[i] = '0;
    endtask

    task automatic write_reg(input logic [4:0] idx, input logic [W-1:0] data);
        @(negedge clock);
        idle_inputs();
        RegWrite = 1'b1; WriteReg = idx; WriteData = data;
        if (idx != 5'd31) model_regs[idx] = data;
        @(negedge clock);
        RegWrite = 1'b0;
    endtask

    // Presents one operation for a single cycle; returns at the sampling point.
    task automatic issue(input logic [1:0] op, input logic [10:0] opc,
                         input logic [4:0] r1, input logic [4:0] r2);
        @(negedge clock);
        idle_inputs();
        in_valid = 1'b1; ALUOp = op; Opcode = opc; Read1 = r1; Read2 = r2;
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [1:0]  op;
        logic [10:0] opc;
        logic [W-1:0] a, b, res;
        logic z, n, c, v;
    } vec_t;

    vec_t vecs [14];

    localparam logic [W-1:0] P5 = 64'h5555_5555_5555_5555;
    localparam logic [W-1:0] PA = 64'hAAAA_AAAA_AAAA_AAAA;
    localparam logic [W-1:0] F1 = 64'hFFFF_FFFF_FFFF_FFFF;

    initial begin
        logic [W+4:0] e;
        logic [W+3:0] m;
        logic [W-1:0] a, b;
        logic [W-1:0] h_res;
        logic [3:0]   h_flags;

        vecs[0]  = '{2'b10, OPC_AND,  P5, PA, 64'h0, 1, 0, 0, 0};
        vecs[1]  = '{2'b10, OPC_ORR,  P5, PA, F1,    0, 1, 0, 0};
        vecs[2]  = '{2'b10, OPC_ADD,  P5, PA, F1,    0, 1, 0, 0};
        vecs[3]  = '{2'b10, OPC_NOR,  P5, PA, 64'h0, 1, 0, 0, 0};
        vecs[4]  = '{2'b10, OPC_PASS, P5, PA, PA,    0, 1, 0, 0};
        vecs[5]  = '{2'b10, OPC_SUB,  P5, PA, 64'hAAAA_AAAA_AAAA_AAAB, 0, 1, 0, 1};
        vecs[6]  = '{2'b10, 11'd0,    P5, PA, 64'h0, 1, 0, 0, 0};
        vecs[7]  = '{2'b00, 11'd0,    F1, 64'h1, 64'h0, 1, 0, 1, 0};
        vecs[8]  = '{2'b10, OPC_SUB,  64'h5, 64'h5, 64'h0, 1, 0, 1, 0};
        vecs[9]  = '{2'b00, 11'd0,    64'h7FFF_FFFF_FFFF_FFFF, 64'h1,
                     64'h8000_0000_0000_0000, 0, 1, 0, 1};
        vecs[10] = '{2'b11, OPC_ADD,  64'h5, 64'h3, 64'h0, 1, 0, 0, 0};
        vecs[11] = '{2'b01, 11'd0,    64'h5, PA, PA,    0, 1, 0, 0};
        vecs[12] = '{2'b10, OPC_SUB,  64'h0, 64'h1, F1, 0, 1, 0, 0};
        vecs[13] = '{2'b10, OPC_SUB,  64'h8000_0000_0000_0000, 64'h1,
                     64'h7FFF_FFFF_FFFF_FFFF, 0, 0, 1, 1};

        // ---- reset state ----
        reset_dut();
        @(negedge clock);
        chk_all("reset", '0);

        // ---- table-driven vectors on R5 / R10 ----
        for (int i = 0; i < 14; i++) begin
            write_reg(5'd5, vecs[i].a);
            write_reg(5'd10, vecs[i].b);
            issue(vecs[i].op, vecs[i].opc, 5'd5, 5'd10);
            chk_all($sformatf("vec%0d", i),
                    {1'b1, vecs[i].res, vecs[i].z, vecs[i].n, vecs[i].c, vecs[i].v});
        end

        // ---- zero register: write ignored, reads 0 ----
        write_reg(5'd31, 64'h1234);
        issue(2'b00, 11'd0, 5'd31, 5'd31);
        chk_all("zr add", {1'b1, 64'h0, 4'b1000});
        write_reg(5'd10, PA);
        issue(2'b01, 11'd0, 5'd31, 5'd10);
        chk_all("passb r10", {1'b1, PA, 4'b0100});
        // Same-cycle write to the zero register must not bypass.
        @(negedge clock);
        idle_inputs();
        RegWrite = 1'b1; WriteReg = 5'd31; WriteData = 64'h99;
        in_valid = 1'b1; ALUOp = 2'b01; Read2 = 5'd31;
        @(negedge clock);
        idle_inputs();
        chk_all("zr bypass", {1'b1, 64'h0, 4'b1000});

        // ---- bypass: write R3=7 and ADD R3,R3 in the same cycle ----
        @(negedge clock);
        idle_inputs();
        RegWrite = 1'b1; WriteReg = 5'd3; WriteData = 64'd7;
        in_valid = 1'b1; ALUOp = 2'b00; Read1 = 5'd3; Read2 = 5'd3;
        model_regs[3] = 64'd7;
        @(negedge clock);
        idle_inputs();
        chk_all("bypass add", {1'b1, 64'd14, 4'b0000});
        @(negedge clock);
        chk_all("hold", {1'b0, 64'd14, 4'b0000});
        issue(2'b01, 11'd0, 5'd0, 5'd3);
        chk_all("r3 stored", {1'b1, 64'd7, 4'b0000});

        // ---- reset mid-run with an operation in flight ----
        write_reg(5'd5, 64'h1234);
        issue(2'b00, 11'd0, 5'd5, 5'd5);
        chk_all("pre-reset", {1'b1, 64'h2468, 4'b0000});
        @(negedge clock);
        in_valid = 1'b1; ALUOp = 2'b00; Read1 = 5'd5; Read2 = 5'd5;
        reset = 1'b1;
        #1;
        chk_all("async rst", '0);
        @(negedge clock);
        chk_all("rst edge", '0);
        idle_inputs();
        reset = 1'b0;
        for (int i = 0; i < 32; i++) model_regs[i] = '0;
        @(negedge clock);
        chk_all("post rst", '0);
        issue(2'b01, 11'd0, 5'd0, 5'd5);
        chk_all("r5 cleared", {1'b1, 64'h0, 4'b1000});

        // ---- randomized stimulus against the reference model ----
        reset_dut();
        h_res = '0; h_flags = '0;
        for (int i = 0; i < 400; i++) begin
            int r;
            @(negedge clock);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk_all($sformatf("rnd%0d", i), e);
            end
            in_valid = ($urandom_range(0, 3) != 0);
            RegWrite = $urandom_range(0, 1);
            r = $urandom_range(0, 8); WriteReg = (r == 8) ? 5'd31 : 5'(r);
            r = $urandom_range(0, 8); Read1    = (r == 8) ? 5'd31 : 5'(r);
            r = $urandom_range(0, 8); Read2    = (r == 8) ? 5'd31 : 5'(r);
            case ($urandom_range(0, 3))
                0: WriteData = {$urandom, $urandom};
                1: WriteData = 64'h8000_0000_0000_0000 - 64'($urandom_range(0, 2));
                2: WriteData = 64'($urandom_range(0, 3));
                default: WriteData = F1 - 64'($urandom_range(0, 2));
            endcase
            ALUOp = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 6))
                0: Opcode = OPC_AND;
                1: Opcode = OPC_ORR;
                2: Opcode = OPC_ADD;
                3: Opcode = OPC_SUB;
                4: Opcode = OPC_PASS;
                5: Opcode = OPC_NOR;
                default: Opcode = 11'($urandom);
            endcase
            a = model_read(Read1, RegWrite, WriteReg, WriteData);
            b = model_read(Read2, RegWrite, WriteReg, WriteData);
            if (in_valid) begin
                m = alu_model(ALUOp, Opcode, a, b);
                h_res = m[W+3:4];
                h_flags = m[3:0];
            end
            exp_q.push_back({in_valid, h_res, h_flags});
            if (RegWrite && WriteReg != 5'd31) model_regs[WriteReg] = WriteData;
        end
        @(negedge clock);
        idle_inputs();
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk_all("rnd last", e);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
